ysyx_23060286_lsu: RTL and testbench

- Load/store unit directly downstream of the single-cycle datapath's ALU.
- Consumes the ALU-computed address, rs2 data, memwrite and funct3.
- Performs one aligned byte/half/word access to data memory over a valid/ready request plus valid response interface.
- Returns the sign- or zero-extended load result that feeds the result mux; drives a stall so PC/register writeback wait for completion.

---
 rtl/ysyx_23060286_lsu_if.sv | 23 ++
 rtl/ysyx_23060286_lsu.sv | 167 ++++++++++++++++
 tb/tb_ysyx_23060286_lsu.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060286_lsu_if.sv
// Data-memory bus between the LSU (master) and memory (slave): valid/ready request, valid-only response.
interface ysyx_23060286_lsu_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_resp_valid;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );
endinterface

// File: rtl/ysyx_23060286_lsu.sv
// Load/store unit: one aligned byte/half/word access per op, returns the extended load result; >=3 cycles accept->done.
// Stalls the core from acceptance to done; holds the request until mem_req_ready, bounded response wait.
module ysyx_23060286_lsu #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_we,
  input  logic [2:0]        in_funct3,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_wdata,
  output logic              stall,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  ysyx_23060286_lsu_if.master mem
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, FINISH} state_t;

  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] CNT_ONE = 1;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic              op_we;
  logic [2:0]        op_f3;
  logic [1:0]        op_sel;
  logic              err_q;
  logic [31:0]       rdata_q;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_wstrb;

  logic        f3_ok, misalign, acc_bad, timeout_hit;
  logic [31:0] st_wdata, ld_data;
  logic [3:0]  st_wstrb;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Stores only have byte/half/word encodings; the unsigned variants are load-only.
  always_comb begin
    f3_ok    = in_we ? (in_funct3 inside {3'b000, 3'b001, 3'b010})
                     : (in_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misalign = ((in_funct3[1:0] == 2'b01) && in_addr[0]) ||
               ((in_funct3 == 3'b010) && (in_addr[1:0] != 2'b00));
    acc_bad  = !f3_ok || misalign;
  end

  always_comb begin
    st_wdata = in_wdata;
    st_wstrb = 4'b1111;
    case (in_funct3[1:0])
      2'b00: begin
        st_wdata = {4{in_wdata[7:0]}};
        st_wstrb = 4'b0001 << in_addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{in_wdata[15:0]}};
        st_wstrb = in_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
    if (!in_we) begin
      st_wdata = '0;
      st_wstrb = '0;
    end
  end

  always_comb begin
    ld_byte = mem.mem_rdata[8*op_sel +: 8];
    ld_half = mem.mem_rdata[16*op_sel[1] +: 16];
    case (op_f3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = mem.mem_rdata;
    endcase
  end

  assign timeout_hit = (TIMEOUT != 0) && (32'(cnt) == 32'(TIMEOUT - 1));

  always_comb begin
    state_nxt     = state;
    in_ready      = 1'b0;
    stall         = 1'b0;
    done          = 1'b0;
    err           = 1'b0;
    mem.mem_req_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = acc_bad ? FINISH : REQ;
      end
      REQ: begin
        stall             = 1'b1;
        mem.mem_req_valid = 1'b1;
        if (mem.mem_req_ready) state_nxt = WAIT_RESP;
      end
      WAIT_RESP: begin
        stall = 1'b1;
        if (mem.mem_resp_valid || timeout_hit) state_nxt = FINISH;
      end
      FINISH: begin
        done      = 1'b1;
        err       = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_we     <= 1'b0;
      op_f3     <= 3'b000;
      op_sel    <= 2'b00;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_wstrb <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) begin
          op_we  <= in_we;
          op_f3  <= in_funct3;
          op_sel <= in_addr[1:0];
          err_q  <= acc_bad;
          cnt    <= '0;
          if (!acc_bad) begin
            req_we    <= in_we;
            req_addr  <= {in_addr[ADDR_W-1:2], 2'b00};
            req_wdata <= st_wdata;
            req_wstrb <= st_wstrb;
          end
        end
        WAIT_RESP: begin
          cnt <= cnt + CNT_ONE;
          // A response in the timeout cycle still counts as a clean completion.
          if (mem.mem_resp_valid) begin
            err_q <= 1'b0;
            if (!op_we) rdata_q <= ld_data;
          end else if (timeout_hit) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign rdata         = rdata_q;
  assign mem.mem_we    = req_we;
  assign mem.mem_addr  = req_addr;
  assign mem.mem_wdata = req_wdata;
  assign mem.mem_wstrb = req_wstrb;
endmodule

// File: tb/tb_ysyx_23060286_lsu.sv
// Directed bench for the LSU: the bench plays data memory with programmable ready/response delays.
module tb_ysyx_23060286_lsu;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid, in_ready, in_we;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_wdata;
  logic        stall, done, err;
  logic [31:0] rdata;

  ysyx_23060286_lsu_if #(.ADDR_W(32)) mem ();

  ysyx_23060286_lsu #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we), .in_funct3(in_funct3),
    .in_addr(in_addr), .in_wdata(in_wdata),
    .stall(stall), .done(done), .err(err), .rdata(rdata),
    .mem(mem)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int          lat, req_cyc;
  logic        saw_req, stable_ok, stall_ok, r_err;
  logic [31:0] r_rdata, c_addr, c_wdata;
  logic [3:0]  c_wstrb;
  logic        c_we;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issues one op and acts as memory: ready after rdy_dly request cycles, response resp_dly cycles into the wait.
  task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       input int rdy_dly, input int resp_dly, input logic [31:0] word);
    int wcnt, rcnt;
    @(negedge clk);
    in_valid = 1'b1; in_we = we; in_funct3 = f3; in_addr = a; in_wdata = wd;
    chk("acc_ready", {31'd0, in_ready}, 32'd1);
    chk("acc_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0; in_we = !we; in_funct3 = 3'b111; in_addr = 32'hFFFF_FFFF; in_wdata = 32'h0;
    lat = 1; wcnt = 0; rcnt = 0; req_cyc = 0;
    saw_req = 1'b0; stable_ok = 1'b1; stall_ok = 1'b1;
    while (done !== 1'b1 && lat < 40) begin
      if (stall !== 1'b1) stall_ok = 1'b0;
      if (mem.mem_req_valid === 1'b1) begin
        if (!saw_req) begin
          c_addr = mem.mem_addr; c_wdata = mem.mem_wdata; c_wstrb = mem.mem_wstrb; c_we = mem.mem_we;
        end else if (mem.mem_addr !== c_addr || mem.mem_wdata !== c_wdata ||
                     mem.mem_wstrb !== c_wstrb || mem.mem_we !== c_we) begin
          stable_ok = 1'b0;
        end
        saw_req = 1'b1;
        req_cyc++;
        mem.mem_req_ready  = (wcnt >= rdy_dly);
        mem.mem_resp_valid = 1'b0;
        wcnt++;
      end else begin
        mem.mem_req_ready  = 1'b0;
        mem.mem_resp_valid = saw_req && (rcnt >= resp_dly);
        mem.mem_rdata      = word;
        if (saw_req) rcnt++;
      end
      @(negedge clk);
      lat++;
    end
    mem.mem_req_ready = 1'b0;
    chk("done_seen", {31'd0, done}, 32'd1);
    r_err   = err;
    r_rdata = rdata;
    mem.mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("done_pulse", {31'd0, done}, 32'd0);
  endtask

  initial begin
    in_valid = 1'b0; in_we = 1'b0; in_funct3 = 3'b000; in_addr = '0; in_wdata = '0;
    mem.mem_req_ready = 1'b0; mem.mem_resp_valid = 1'b0; mem.mem_rdata = '0;

    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_req_valid", {31'd0, mem.mem_req_valid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem_addr", mem.mem_addr, 32'd0);
    chk("rst_mem_wdata", mem.mem_wdata, 32'd0);
    chk("rst_mem_wstrb", {28'd0, mem.mem_wstrb}, 32'd0);
    chk("rst_mem_we", {31'd0, mem.mem_we}, 32'd0);
    rst = 1'b1;

    do_op(1'b0, 3'b010, 32'h8000_0004, 32'h0, 0, 0, 32'hDEAD_BEEF);
    chk("lw_lat", lat, 3);
    chk("lw_rdata", r_rdata, 32'hDEAD_BEEF);
    chk("lw_err", {31'd0, r_err}, 32'd0);
    chk("lw_addr", c_addr, 32'h8000_0004);
    chk("lw_wstrb", {28'd0, c_wstrb}, 32'd0);
    chk("lw_we", {31'd0, c_we}, 32'd0);
    chk("lw_stall", {31'd0, stall_ok}, 32'd1);

    do_op(1'b0, 3'b000, 32'h8000_0003, 32'h0, 0, 0, 32'h8011_2233);
    chk("lb_rdata", r_rdata, 32'hFFFF_FF80);
    chk("lb_addr", c_addr, 32'h8000_0000);
    do_op(1'b0, 3'b100, 32'h8000_0003, 32'h0, 0, 0, 32'h8011_2233);
    chk("lbu_rdata", r_rdata, 32'h0000_0080);
    do_op(1'b0, 3'b101, 32'h8000_0002, 32'h0, 0, 0, 32'h8011_2233);
    chk("lhu_rdata", r_rdata, 32'h0000_8011);
    do_op(1'b0, 3'b001, 32'h8000_0002, 32'h0, 0, 0, 32'h8011_2233);
    chk("lh_rdata", r_rdata, 32'hFFFF_8011);
    do_op(1'b0, 3'b001, 32'h8000_0000, 32'h0, 0, 0, 32'h8011_2233);
    chk("lh_lo_rdata", r_rdata, 32'h0000_2233);
    do_op(1'b0, 3'b000, 32'h8000_0001, 32'h0, 0, 0, 32'h8011_2233);
    chk("lb_b1_rdata", r_rdata, 32'h0000_0022);

    do_op(1'b1, 3'b000, 32'h8000_0001, 32'h0000_00AB, 0, 0, 32'h5555_5555);
    chk("sb_we", {31'd0, c_we}, 32'd1);
    chk("sb_wstrb", {28'd0, c_wstrb}, 32'h2);
    chk("sb_wdata", c_wdata, 32'hABAB_ABAB);
    chk("sb_addr", c_addr, 32'h8000_0000);
    chk("sb_rdata_kept", r_rdata, 32'h0000_0022);
    chk("sb_err", {31'd0, r_err}, 32'd0);
    do_op(1'b1, 3'b001, 32'h8000_0002, 32'h0000_1234, 0, 0, 32'h0);
    chk("sh_wstrb", {28'd0, c_wstrb}, 32'hC);
    chk("sh_wdata", c_wdata, 32'h1234_1234);
    chk("sh_addr", c_addr, 32'h8000_0000);
    do_op(1'b1, 3'b010, 32'h8000_0008, 32'hCAFE_F00D, 0, 0, 32'h0);
    chk("sw_wstrb", {28'd0, c_wstrb}, 32'hF);
    chk("sw_wdata", c_wdata, 32'hCAFE_F00D);
    chk("sw_addr", c_addr, 32'h8000_0008);

    do_op(1'b0, 3'b010, 32'h8000_0002, 32'h0, 0, 0, 32'h0);
    chk("mis_req", {31'd0, saw_req}, 32'd0);
    chk("mis_err", {31'd0, r_err}, 32'd1);
    chk("mis_lat", lat, 1);
    chk("mis_rdata", r_rdata, 32'h0000_0022);
    do_op(1'b0, 3'b011, 32'h8000_0000, 32'h0, 0, 0, 32'h0);
    chk("ill_req", {31'd0, saw_req}, 32'd0);
    chk("ill_err", {31'd0, r_err}, 32'd1);
    chk("ill_lat", lat, 1);
    do_op(1'b1, 3'b001, 32'h8000_0003, 32'h0, 0, 0, 32'h0);
    chk("mis_sh_req", {31'd0, saw_req}, 32'd0);
    chk("mis_sh_err", {31'd0, r_err}, 32'd1);

    do_op(1'b0, 3'b010, 32'h8000_0010, 32'h0, 5, 0, 32'h0102_0304);
    chk("bp_req_cyc", req_cyc, 6);
    chk("bp_stable", {31'd0, stable_ok}, 32'd1);
    chk("bp_stall", {31'd0, stall_ok}, 32'd1);
    chk("bp_lat", lat, 8);
    chk("bp_rdata", r_rdata, 32'h0102_0304);

    do_op(1'b0, 3'b010, 32'h8000_0014, 32'h0, 0, 100, 32'h7777_7777);
    chk("to_lat", lat, 6);
    chk("to_err", {31'd0, r_err}, 32'd1);
    chk("to_rdata", r_rdata, 32'd0);
    do_op(1'b0, 3'b010, 32'h8000_0018, 32'h0, 0, 3, 32'h0BAD_F00D);
    chk("race_lat", lat, 6);
    chk("race_err", {31'd0, r_err}, 32'd0);
    chk("race_rdata", r_rdata, 32'h0BAD_F00D);

    @(negedge clk);
    in_valid = 1'b1; in_we = 1'b0; in_funct3 = 3'b010; in_addr = 32'h8000_001C;
    @(negedge clk);
    in_valid = 1'b0; mem.mem_req_ready = 1'b1;
    @(negedge clk);
    mem.mem_req_ready = 1'b0;
    chk("mid_stall_pre", {31'd0, stall}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_stall", {31'd0, stall}, 32'd0);
    chk("mid_req_valid", {31'd0, mem.mem_req_valid}, 32'd0);
    chk("mid_rdata", rdata, 32'd0);
    chk("mid_mem_addr", mem.mem_addr, 32'd0);
    chk("mid_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    do_op(1'b0, 3'b010, 32'h8000_0020, 32'h0, 0, 0, 32'h1122_3344);
    chk("post_lat", lat, 3);
    chk("post_rdata", r_rdata, 32'h1122_3344);
    chk("post_err", {31'd0, r_err}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end
endmodule
